// File: rtl/renode_apb3_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : renode_apb3_arbiter
// Description : Round-robin arbiter and APB3 master sequencer. Shares one APB3
//               bus between NUM_REQUESTERS requesters, runs SETUP/ACCESS with
//               a per-transfer wait-state timeout and returns read data and
//               error status to the granted requester.
// Revision    : 1.0 - initial release
// ============================================================================
module renode_apb3_arbiter #(
    parameter int NUM_REQUESTERS = 2,
    parameter int ADDRESS_WIDTH  = 20,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                    pclk,
    input  logic                                    preset,
    input  logic [NUM_REQUESTERS-1:0]               req_valid,
    input  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQUESTERS-1:0]               req_write,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQUESTERS-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]                   rsp_rdata,
    output logic                                    rsp_err,
    output logic                                    busy,
    output logic [ADDRESS_WIDTH-1:0]                paddr,
    output logic                                    psel,
    output logic                                    penable,
    output logic                                    pwrite,
    output logic [DATA_WIDTH-1:0]                   pwdata,
    input  logic                                    pready,
    input  logic [DATA_WIDTH-1:0]                   prdata,
    input  logic                                    pslverr
);

    localparam int c_idx_w  = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam int c_tcnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit c_tmo_en = (TIMEOUT_CYCLES > 0);
    localparam logic [c_tcnt_w-1:0] c_tmo_last =
        (TIMEOUT_CYCLES > 0) ? c_tcnt_w'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_REQUESTERS - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    // Parameter sanity checks at elaboration
    if (NUM_REQUESTERS < 1) begin : g_bad_num_requesters
        $error("renode_apb3_arbiter: NUM_REQUESTERS must be >= 1");
    end
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 24 || DATA_WIDTH == 32))
    begin : g_bad_data_width
        $error("renode_apb3_arbiter: DATA_WIDTH must be 8, 16, 24 or 32");
    end

    logic [1:0]                r_state;
    logic [c_idx_w-1:0]        r_ptr;
    logic [c_idx_w-1:0]        r_idx;
    logic [c_tcnt_w-1:0]       r_tcnt;
    logic [NUM_REQUESTERS-1:0] r_rsp_valid;
    logic [DATA_WIDTH-1:0]     r_rsp_rdata;
    logic                      r_rsp_err;
    logic                      r_busy;
    logic [ADDRESS_WIDTH-1:0]  r_paddr;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_pwrite;
    logic [DATA_WIDTH-1:0]     r_pwdata;

    logic [c_idx_w-1:0]        w_win_idx;
    logic                      w_win_any;
    logic [ADDRESS_WIDTH-1:0]  w_win_addr;
    logic [DATA_WIDTH-1:0]     w_win_wdata;
    logic [NUM_REQUESTERS-1:0] w_idx_onehot;

    // Round-robin pick: first valid at index >= ptr, else first valid below ptr.
    // The second loop runs last so the >= ptr region overrides the wrap region;
    // descending iteration leaves the lowest index as the final assignment.
    always_comb begin
        w_win_idx = '0;
        w_win_any = 1'b0;
        for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
            if (req_valid[i] && (c_idx_w'(i) < r_ptr)) begin
                w_win_idx = c_idx_w'(i);
                w_win_any = 1'b1;
            end
        end
        for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
            if (req_valid[i] && (c_idx_w'(i) >= r_ptr)) begin
                w_win_idx = c_idx_w'(i);
                w_win_any = 1'b1;
            end
        end
    end

    assign w_win_addr   = req_addr[w_win_idx * ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign w_win_wdata  = req_wdata[w_win_idx * DATA_WIDTH +: DATA_WIDTH];
    assign w_idx_onehot = NUM_REQUESTERS'(1) << r_idx;

    // Transfer sequencer: grant, SETUP, ACCESS with timeout, one-cycle response
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state     <= c_st_idle;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_tcnt      <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_paddr     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_win_any) begin
                        r_idx    <= w_win_idx;
                        r_paddr  <= w_win_addr;
                        r_pwrite <= req_write[w_win_idx];
                        r_pwdata <= w_win_wdata;
                        r_psel   <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= c_st_setup;
                    end
                end
                c_st_setup: begin
                    r_penable <= 1'b1;
                    r_tcnt    <= '0;
                    r_state   <= c_st_access;
                end
                c_st_access: begin
                    // pready is checked first so a late ready beats the timeout
                    if (pready) begin
                        r_rsp_rdata <= r_pwrite ? '0 : prdata;
                        r_rsp_err   <= pslverr;
                        r_rsp_valid <= w_idx_onehot;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= c_st_done;
                    end else if (c_tmo_en && (r_tcnt == c_tmo_last)) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= w_idx_onehot;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= c_st_done;
                    end else begin
                        r_tcnt <= r_tcnt + c_tcnt_w'(1);
                    end
                end
                c_st_done: begin
                    r_rsp_valid <= '0;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_ptr       <= (r_idx == c_last_idx) ? '0 : r_idx + c_idx_w'(1);
                    r_state     <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;
    assign paddr     = r_paddr;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_renode_apb3_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_renode_apb3_arbiter
// Description : Directed self-checking bench for renode_apb3_arbiter with
//               three requesters and an eight-cycle ACCESS timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_renode_apb3_arbiter;

    localparam int c_n   = 3;
    localparam int c_aw  = 20;
    localparam int c_dw  = 32;
    localparam int c_tmo = 8;

    logic                  pclk = 1'b0;
    logic                  preset;
    logic [c_n-1:0]        req_valid;
    logic [c_n*c_aw-1:0]   req_addr;
    logic [c_n-1:0]        req_write;
    logic [c_n*c_dw-1:0]   req_wdata;
    logic [c_n-1:0]        rsp_valid;
    logic [c_dw-1:0]       rsp_rdata;
    logic                  rsp_err;
    logic                  busy;
    logic [c_aw-1:0]       paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [c_dw-1:0]       pwdata;
    logic                  pready;
    logic [c_dw-1:0]       prdata;
    logic                  pslverr;

    int checks   = 0;
    int failures = 0;

    renode_apb3_arbiter #(
        .NUM_REQUESTERS(c_n),
        .ADDRESS_WIDTH (c_aw),
        .DATA_WIDTH    (c_dw),
        .TIMEOUT_CYCLES(c_tmo)
    ) u_dut (
        .pclk     (pclk),
        .preset   (preset),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_write(req_write),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pready   (pready),
        .prdata   (prdata),
        .pslverr  (pslverr)
    );

    always #5 pclk = ~pclk;

    // Advance one clock edge and settle 1 time unit past it
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : main
        logic [c_n-1:0] exp_order [5];
        int             pen_cnt;
        bit             got_rsp;

        preset    = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_psel",      psel,      1'b0);
        check("rst_penable",   penable,   1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_rsp_valid", rsp_valid, 3'b000);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err",   rsp_err,   1'b0);
        check("rst_paddr",     paddr,     20'h0);
        check("rst_pwrite",    pwrite,    1'b0);
        check("rst_pwdata",    pwdata,    32'h0);
        preset = 1'b0;

        // 1: req0 zero-wait read
        req_valid         = 3'b001;
        req_addr[0+:c_aw] = 20'h00010;
        req_write[0]      = 1'b0;
        pready            = 1'b1;
        prdata            = 32'hDEADBEEF;
        tick();
        check("t1_setup_psel",    psel,    1'b1);
        check("t1_setup_penable", penable, 1'b0);
        check("t1_setup_busy",    busy,    1'b1);
        check("t1_paddr",         paddr,   20'h00010);
        check("t1_pwrite",        pwrite,  1'b0);
        tick();
        check("t1_access_penable", penable,   1'b1);
        check("t1_access_rsp",     rsp_valid, 3'b000);
        tick();
        check("t1_rsp_valid", rsp_valid, 3'b001);
        check("t1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        check("t1_rsp_err",   rsp_err,   1'b0);
        check("t1_done_psel", psel,      1'b0);
        check("t1_done_busy", busy,      1'b1);
        req_valid = 3'b000;
        tick();
        check("t1_idle_rsp",   rsp_valid, 3'b000);
        check("t1_idle_rdata", rsp_rdata, 32'h0);
        check("t1_idle_busy",  busy,      1'b0);
        check("t1_hold_paddr", paddr,     20'h00010);

        // 2: req1 write with three wait states; request changes are ignored
        req_valid             = 3'b010;
        req_addr[c_aw+:c_aw]  = 20'h0A5A5;
        req_write[1]          = 1'b1;
        req_wdata[c_dw+:c_dw] = 32'h12345678;
        pready                = 1'b0;
        prdata                = 32'hCAFEF00D;
        tick();
        check("t2_setup_pwrite", pwrite, 1'b1);
        req_addr[c_aw+:c_aw]  = 20'h11111;
        req_wdata[c_dw+:c_dw] = 32'h99999999;
        pen_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (penable) pen_cnt++;
            check("t2_paddr_stable",  paddr,     20'h0A5A5);
            check("t2_pwdata_stable", pwdata,    32'h12345678);
            check("t2_no_rsp",        rsp_valid, 3'b000);
        end
        tick();
        if (penable) pen_cnt++;
        check("t2_paddr_last", paddr, 20'h0A5A5);
        pready = 1'b1;
        tick();
        check("t2_penable_cycles", pen_cnt,   4);
        check("t2_rsp_valid",      rsp_valid, 3'b010);
        check("t2_rsp_rdata",      rsp_rdata, 32'h0);
        check("t2_rsp_err",        rsp_err,   1'b0);
        check("t2_done_penable",   penable,   1'b0);
        req_valid = 3'b000;
        tick();

        // 3: round-robin with all requesters held, starting from reset
        preset = 1'b1;
        tick();
        preset    = 1'b0;
        req_write = 3'b000;
        req_valid = 3'b111;
        pready    = 1'b1;
        prdata    = 32'h0000A0A0;
        exp_order[0] = 3'b001;
        exp_order[1] = 3'b010;
        exp_order[2] = 3'b100;
        exp_order[3] = 3'b001;
        exp_order[4] = 3'b010;
        for (int t = 0; t < 5; t++) begin
            tick();
            check("t3_setup_no_rsp", rsp_valid, 3'b000);
            tick();
            check("t3_access_no_rsp", rsp_valid, 3'b000);
            tick();
            check("t3_grant", rsp_valid, exp_order[t]);
            check("t3_rdata", rsp_rdata, 32'h0000A0A0);
            tick();
            check("t3_pulse_one_cycle", rsp_valid, 3'b000);
        end
        req_valid = 3'b000;
        tick();

        // 4a: req2 read with pready stuck low -> timeout after 8 ACCESS cycles
        req_valid              = 3'b100;
        req_addr[2*c_aw+:c_aw] = 20'hFFFFF;
        pready                 = 1'b0;
        prdata                 = 32'h55555555;
        pen_cnt                = 0;
        got_rsp                = 1'b0;
        for (int i = 0; i < 20 && !got_rsp; i++) begin
            tick();
            if (rsp_valid != 3'b000) got_rsp = 1'b1;
            else if (penable) pen_cnt++;
        end
        check("t4_rsp_seen",       got_rsp,   1'b1);
        check("t4_access_cycles",  pen_cnt,   8);
        check("t4_rsp_valid",      rsp_valid, 3'b100);
        check("t4_rsp_err",        rsp_err,   1'b1);
        check("t4_rsp_rdata",      rsp_rdata, 32'h0);
        req_valid = 3'b000;
        tick();

        // 4b: req0 read, pready rises in the 8th ACCESS cycle -> no error
        req_valid         = 3'b001;
        req_addr[0+:c_aw] = 20'h00ABC;
        prdata            = 32'h13579BDF;
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t4b_no_early_rsp", rsp_valid, 3'b000);
        end
        check("t4b_still_access", penable, 1'b1);
        pready = 1'b1;
        tick();
        check("t4b_rsp_valid", rsp_valid, 3'b001);
        check("t4b_rsp_err",   rsp_err,   1'b0);
        check("t4b_rsp_rdata", rsp_rdata, 32'h13579BDF);
        req_valid = 3'b000;
        tick();

        // 5a: req1 read with slave error
        req_valid    = 3'b010;
        req_write[1] = 1'b0;
        pready       = 1'b1;
        pslverr      = 1'b1;
        prdata       = 32'h0000FFFF;
        tick();
        tick();
        tick();
        check("t5_rd_rsp_valid", rsp_valid, 3'b010);
        check("t5_rd_rsp_err",   rsp_err,   1'b1);
        check("t5_rd_rsp_rdata", rsp_rdata, 32'h0000FFFF);
        req_valid = 3'b000;
        tick();

        // 5b: req2 write with slave error
        req_valid                = 3'b100;
        req_write[2]             = 1'b1;
        req_wdata[2*c_dw+:c_dw]  = 32'hA5A5A5A5;
        tick();
        tick();
        tick();
        check("t5_wr_rsp_valid", rsp_valid, 3'b100);
        check("t5_wr_rsp_err",   rsp_err,   1'b1);
        check("t5_wr_rsp_rdata", rsp_rdata, 32'h0);
        req_valid = 3'b000;
        pslverr   = 1'b0;
        tick();

        // 6: move ptr to 1, then reset in the 2nd ACCESS cycle of a req1 read
        req_valid = 3'b001;
        tick();
        tick();
        tick();
        check("t6_pre_rsp", rsp_valid, 3'b001);
        req_valid = 3'b000;
        tick();
        req_valid    = 3'b010;
        req_write[1] = 1'b0;
        pready       = 1'b0;
        tick();
        tick();
        tick();
        check("t6_in_access2", penable, 1'b1);
        preset = 1'b1;
        tick();
        check("t6_rst_psel",    psel,      1'b0);
        check("t6_rst_penable", penable,   1'b0);
        check("t6_rst_rsp",     rsp_valid, 3'b000);
        preset            = 1'b0;
        req_valid         = 3'b011;
        req_addr[0+:c_aw] = 20'h00777;
        req_addr[c_aw+:c_aw] = 20'h00888;
        req_write         = 3'b000;
        pready            = 1'b1;
        tick();
        check("t6_winner_paddr", paddr, 20'h00777);
        tick();
        tick();
        check("t6_winner_rsp", rsp_valid, 3'b001);
        req_valid = 3'b000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
